// File: rtl/sdrd_unlock_seq.sv
// SDRD unlock sequencer: matches a 4-nibble key on window reads, then serialises
// a captured ID word LSB-first, one bit per window read, with relock and timeout.
module sdrd_unlock_seq #(
  parameter logic [15:0] KEY     = 16'h29A5,
  parameter int          ID_BITS = 16,
  parameter int          TIMEOUT = 1024,
  parameter int          TW      = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_stb,
  input  logic        sser_n,
  input  logic [13:0] ba,
  input  logic        br_w,
  input  logic [15:0] id_word,
  output logic        sdrd,
  output logic        sdrd_oe,
  output logic        unlocked,
  output logic [2:0]  state,
  output logic [3:0]  bit_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    K1    = 3'd1,
    K2    = 3'd2,
    K3    = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0]    KEY0     = KEY[15:12];
  localparam logic [3:0]    KEY1     = KEY[11:8];
  localparam logic [3:0]    KEY2     = KEY[7:4];
  localparam logic [3:0]    KEY3     = KEY[3:0];
  localparam logic [3:0]    LAST_IDX = 4'(ID_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          sdrd_q, sdrd_d;
  logic          sdrd_oe_q, sdrd_oe_d;
  logic          unlocked_q, unlocked_d;

  logic       win;
  logic       rd;
  logic [3:0] nib;
  logic [3:0] nxt_idx;

  assign win     = cyc_stb & ~sser_n & ~ba[13] & ba[12];
  assign rd      = win & br_w;
  assign nib     = ba[7:4];
  assign nxt_idx = bit_idx_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      sdrd_q     <= 1'b0;
      sdrd_oe_q  <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      sdrd_q     <= sdrd_d;
      sdrd_oe_q  <= sdrd_oe_d;
      unlocked_q <= unlocked_d;
    end
  end

  // A window cycle always beats timeout expiry; non-window cycles only age the counter.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    if (win) begin
      if (!br_w) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_d = (nib == KEY0) ? K1 : IDLE;
          K1:      state_d = (nib == KEY1) ? K2    : ((nib == KEY0) ? K1 : IDLE);
          K2:      state_d = (nib == KEY2) ? K3    : ((nib == KEY0) ? K1 : IDLE);
          K3:      state_d = (nib == KEY3) ? SHIFT : ((nib == KEY0) ? K1 : IDLE);
          SHIFT:   state_d = (bit_idx_q == LAST_IDX) ? DONE : SHIFT;
          DONE:    state_d = (nib == 4'hF) ? IDLE : DONE;
          default: state_d = IDLE;
        endcase
      end
    end else begin
      case (state_q)
        K1, K2, K3, SHIFT: begin
          if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shreg_d    = shreg_q;
    bit_idx_d  = '0;
    sdrd_d     = 1'b0;
    sdrd_oe_d  = (state_d == SHIFT);
    unlocked_d = (state_d == SHIFT) || (state_d == DONE);
    if (state_d == SHIFT) begin
      if (state_q != SHIFT) begin
        shreg_d   = id_word;
        bit_idx_d = '0;
        sdrd_d    = id_word[0];
      end else if (rd) begin
        bit_idx_d = nxt_idx;
        sdrd_d    = shreg_q[nxt_idx];
      end else begin
        bit_idx_d = bit_idx_q;
        sdrd_d    = sdrd_q;
      end
    end
  end

  assign sdrd     = sdrd_q;
  assign sdrd_oe  = sdrd_oe_q;
  assign unlocked = unlocked_q;
  assign state    = state_q;
  assign bit_idx  = bit_idx_q;

endmodule
